// File: rtl/fifo_pack_reader.sv
// fifo_pack_reader: drains a one-cycle-latency byte FIFO and packs PACK_NUM entries,
// LSB lane first, into valid/ready words with a keep mask and a flush-driven last flag.
module fifo_pack_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int PACK_NUM   = 4
) (
    input  logic                           clock,
    input  logic                           pack_rst_n,
    input  logic                           fifo_empty,
    input  logic [ADDR_WIDTH-1:0]          fifo_counter,
    input  logic [DATA_WIDTH-1:0]          fifo_read_data,
    output logic                           fifo_read_enable,
    input  logic                           flush,
    output logic [DATA_WIDTH*PACK_NUM-1:0] m_data,
    output logic [PACK_NUM-1:0]            m_keep,
    output logic                           m_last,
    output logic                           m_valid,
    input  logic                           m_ready
);
    localparam int CW = $clog2(PACK_NUM) + 1;
    localparam int WW = DATA_WIDTH * PACK_NUM;
    localparam logic [CW-1:0] FULL = CW'(PACK_NUM);

    logic [CW-1:0]       lane_cnt_q, lane_cnt_d, lane_nxt;
    logic                rd_pending_q, rd_pending_d;
    logic                flush_pend_q, flush_pend_d;
    logic [WW-1:0]       asm_q, asm_d, part_data;
    logic [WW-1:0]       m_data_q, m_data_d;
    logic [PACK_NUM-1:0] m_keep_q, m_keep_d, part_keep;
    logic                m_last_q, m_last_d;
    logic                m_valid_q, m_valid_d;
    logic                out_free, fl, emit_full, emit_part;

    assign fifo_read_enable = pack_rst_n && !fifo_empty && (fifo_counter != '0) && !flush_pend_q &&
                              ((lane_cnt_q + CW'(rd_pending_q)) < FULL);

    always_comb begin
        out_free = !m_valid_q || m_ready;
        // a flush pulse on the completing capture still marks that word as last
        fl = flush_pend_q || (flush && ((lane_cnt_q != '0) || rd_pending_q));
        asm_d = asm_q;
        lane_nxt = lane_cnt_q;
        if (rd_pending_q) begin
            for (int i = 0; i < PACK_NUM; i++)
                if (lane_cnt_q == CW'(i)) asm_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_read_data;
            lane_nxt = lane_cnt_q + CW'(1);
        end
        for (int i = 0; i < PACK_NUM; i++) begin
            part_keep[i] = CW'(i) < lane_cnt_q;
            part_data[i*DATA_WIDTH +: DATA_WIDTH] = part_keep[i] ? asm_q[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
        emit_full = (lane_nxt == FULL) && out_free;
        emit_part = flush_pend_q && !rd_pending_q && out_free && (lane_cnt_q != '0);
        m_valid_d = m_valid_q && !m_ready;
        m_data_d = m_data_q;
        m_keep_d = m_keep_q;
        m_last_d = m_last_q;
        if (emit_full) begin
            m_valid_d = 1'b1;
            m_data_d = asm_d;
            m_keep_d = '1;
            m_last_d = fl;
        end else if (emit_part) begin
            m_valid_d = 1'b1;
            m_data_d = part_data;
            m_keep_d = part_keep;
            m_last_d = 1'b1;
        end
        lane_cnt_d = (emit_full || emit_part) ? '0 : lane_nxt;
        flush_pend_d = (emit_full || emit_part) ? 1'b0 : fl;
        rd_pending_d = fifo_read_enable;
    end

    always_ff @(posedge clock or negedge pack_rst_n) begin
        if (!pack_rst_n) begin
            lane_cnt_q   <= '0;
            rd_pending_q <= 1'b0;
            flush_pend_q <= 1'b0;
            asm_q        <= '0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
            m_valid_q    <= 1'b0;
        end else begin
            lane_cnt_q   <= lane_cnt_d;
            rd_pending_q <= rd_pending_d;
            flush_pend_q <= flush_pend_d;
            asm_q        <= asm_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
            m_valid_q    <= m_valid_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;
    assign m_valid = m_valid_q;
endmodule

// File: doc/fifo_pack_reader.md
Name: fifo_pack_reader

Overview:
- Drain stage directly downstream of the team's synchronous byte FIFO (registered empty, occupancy counter, one-cycle read latency).
- Pops DATA_WIDTH entries and packs PACK_NUM of them, LSB lane first, into one output word.
- Presents each word on a valid/ready stream, with a byte-keep mask and a last flag for flushed partial words.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry.
- ADDR_WIDTH, 9, width of the FIFO occupancy counter.
- PACK_NUM, 4, FIFO entries per output word. Legal range is 2..8.

Ports:
- clock  input  1  single clock for all logic.
- pack_rst_n  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  registered empty flag from the FIFO.
- fifo_counter  input  ADDR_WIDTH  FIFO occupancy.
- fifo_read_data  input  DATA_WIDTH  FIFO read data, valid one cycle after an accepted read.
- fifo_read_enable  output  1  read strobe to the FIFO.
- flush  input  1  single-cycle request to emit the pending partial word.
- m_data  output  DATA_WIDTH*PACK_NUM  packed word; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_keep  output  PACK_NUM  lane-valid mask.
- m_last  output  1  marks a word emitted by flush.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Port names are clock and pack_rst_n.
- Reset values: m_valid=0, m_data=0, m_keep=0, m_last=0, fifo_read_enable=0. Internal state also clears: lane_cnt=0, rd_pending=0, flush_pend=0.
- Reset may assert at any time and discards the partial word and any in-flight read.
- Read issue is combinational: fifo_read_enable = !fifo_empty && (fifo_counter != 0) && !flush_pend && (lane_cnt + rd_pending < PACK_NUM).
  - Both flags are required. The registered empty lags the counter by one cycle, and an issued read must never be refused by the FIFO.
- rd_pending is set for one cycle after each issued read.
- Capture: when rd_pending=1, fifo_read_data is written into lane lane_cnt of the assembly register and lane_cnt increments.
- Word completion: when the capture fills lane PACK_NUM-1 and the output register is free (m_valid=0, or m_valid&&m_ready this cycle):
  - the word loads into m_data next edge, with m_keep all ones and m_last=0;
  - lane_cnt returns to 0.
- Stall: if the output register is occupied and not accepted, lane_cnt holds at PACK_NUM and no reads issue. The word transfers on the first cycle the output register frees.
- Output handshake: m_valid stays high until m_valid&&m_ready. m_data, m_keep and m_last are stable while m_valid=1 && m_ready=0.
- Flush: a flush pulse sets flush_pend when lane_cnt>0 or rd_pending=1; otherwise it is ignored.
  - While flush_pend=1, no new reads issue.
  - Once rd_pending=0 and the output register is free, the partial word loads. Unused lanes are 0, m_keep has the low lane_cnt bits set, and m_last=1.
  - flush_pend and lane_cnt then clear.
  - A flush arriving while flush_pend=1 has no further effect.
- Flush landing on a full word: if flush_pend=1 and the pending read completes lane PACK_NUM-1, the word is emitted as a normal full word. It has m_keep all ones and m_last=1, and flush_pend clears.
- Throughput: sustained PACK_NUM FIFO entries per PACK_NUM+1 cycles. There is one issue bubble per word, on the cycle the last lane is captured.
- Width rule: lane_cnt and rd_pending arithmetic is done in $clog2(PACK_NUM)+1 bits, so the PACK_NUM comparison cannot wrap.

Test Plan:
- Preload FIFO with 0x11..0x18, PACK_NUM=4, m_ready=1 -> two words, m_data=0x14131211 then 0x18171615, m_keep=4'hF, m_last=0; exactly 8 read strobes; spacing 5 cycles per word.
- FIFO holds 3 entries 0xA1,0xA2,0xA3, then pulse flush -> one word m_data=0x00A3A2A1, m_keep=4'h7, m_last=1; no read strobe issued after the flush is latched.
- Hold m_ready=0 with 12 entries available -> exactly 8 reads; first word held stable on m_data; second word waits in assembly. Release m_ready -> both words delivered in order; reads resume.
- Single write into an empty FIFO (counter=1 while fifo_empty is still 1) -> no read strobe that cycle; read issues on the first cycle both flags allow; never more reads than entries written.
- Flush pulse in the same cycle as the read for lane 3 -> full word emitted with m_keep=4'hF, m_last=1; no second, empty word.
- Assert pack_rst_n=0 with 2 lanes assembled and m_valid=1 -> all outputs 0 immediately; after release, the next 4 entries form a fresh word starting at lane 0.
